greenhouse_climate_ctrl: RTL and testbench

Sequential climate controller for the greenhouse heater and cooler. It takes the two temperature-threshold sensor bits and drives the heater and cooler outputs. It enforces a minimum on-time, a dead time between heating and cooling, and a filtered, latched sensor-inconsistency fault. It sits between the switch inputs (SWI) and the LED/SEG outputs in `top`, with its state exported for the LCD debug registers.

---
 rtl/greenhouse_climate_ctrl_if.sv | 22 ++
 rtl/greenhouse_climate_ctrl.sv | 123 ++++++++++++
 tb/tb_greenhouse_climate_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/greenhouse_climate_ctrl_if.sv
// Sensor inputs, fault acknowledge and drive/status outputs of the greenhouse
// climate controller, grouped so the stimulus side and the controller share a
// single bundle. The master drives the sensors, the slave is the controller.
interface greenhouse_climate_ctrl_if;
  logic       t1;         // temperature >= 15 C
  logic       t2;         // temperature >= 20 C
  logic       clr_fault;  // fault acknowledge, level-sampled
  logic       heater;     // heater drive
  logic       cooler;     // cooler drive
  logic       fault;      // latched inconsistency indicator
  logic [2:0] state;      // current FSM encoding for the LCD debug registers

  modport master (
    output t1, t2, clr_fault,
    input  heater, cooler, fault, state
  );

  modport slave (
    input  t1, t2, clr_fault,
    output heater, cooler, fault, state
  );
endinterface

// File: rtl/greenhouse_climate_ctrl.sv
// Greenhouse heater/cooler controller. Decodes two threshold sensors into
// heat/cool demand, enforces a minimum on-time and a dead time between the two
// actuators, and latches a filtered sensor-inconsistency fault until it is
// acknowledged while the sensors agree again.
module greenhouse_climate_ctrl #(
  parameter int MIN_ON     = 4,
  parameter int DEAD       = 2,
  parameter int FAULT_FILT = 3,
  parameter int CNT_W      = 8
) (
  input  logic                      clk_2,
  input  logic                      reset_n,
  greenhouse_climate_ctrl_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HEAT  = 3'd1;
  localparam logic [2:0] ST_COOL  = 3'd2;
  localparam logic [2:0] ST_DEAD  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);
  localparam logic [CNT_W-1:0] INC_LAST  = CNT_W'(FAULT_FILT - 1);
  localparam logic [CNT_W-1:0] INC_MAX   = CNT_W'(FAULT_FILT);

  logic             heat_req, cool_req, incons, fault_hit;
  logic [2:0]       state_d, state_q;
  logic [CNT_W-1:0] on_cnt_d, on_cnt_q;
  logic [CNT_W-1:0] dead_cnt_d, dead_cnt_q;
  logic [CNT_W-1:0] inc_cnt_d, inc_cnt_q;
  logic             heater_d, heater_q;
  logic             cooler_d, cooler_q;
  logic             fault_d, fault_q;

  // Sensor decode and inconsistency filter: inc_cnt counts the run of
  // consecutive inconsistent cycles before the current one.
  always_comb begin
    heat_req  = !bus.t1 && !bus.t2;
    cool_req  =  bus.t1 &&  bus.t2;
    incons    = !bus.t1 &&  bus.t2;
    fault_hit = incons && (inc_cnt_q == INC_LAST);
    if (!incons)                 inc_cnt_d = '0;
    else if (inc_cnt_q == INC_MAX) inc_cnt_d = inc_cnt_q;
    else                         inc_cnt_d = inc_cnt_q + 1'b1;
  end

  // Next-state logic; fault_hit overrides min-on and dead time in every
  // non-fault state.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    on_cnt_d   = on_cnt_q;
    dead_cnt_d = dead_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (fault_hit)     state_d = ST_FAULT;
        else if (heat_req) state_d = ST_HEAT;
        else if (cool_req) state_d = ST_COOL;
      end
      ST_HEAT: begin
        if (fault_hit)                          state_d  = ST_FAULT;
        else if (on_cnt_q >= ON_LAST && !heat_req) state_d = ST_DEAD;
        else if (on_cnt_q != ON_LAST)           on_cnt_d = on_cnt_q + 1'b1;
      end
      ST_COOL: begin
        if (fault_hit)                          state_d  = ST_FAULT;
        else if (on_cnt_q >= ON_LAST && !cool_req) state_d = ST_DEAD;
        else if (on_cnt_q != ON_LAST)           on_cnt_d = on_cnt_q + 1'b1;
      end
      ST_DEAD: begin
        if (fault_hit)                    state_d    = ST_FAULT;
        else if (dead_cnt_q == DEAD_LAST) state_d    = ST_IDLE;
        else                              dead_cnt_d = dead_cnt_q + 1'b1;
      end
      ST_FAULT: begin
        if (bus.clr_fault && !incons) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Every state starts with fresh timers.
    if (state_d != state_q) begin
      on_cnt_d   = '0;
      dead_cnt_d = '0;
    end

    heater_d = (state_d == ST_HEAT);
    cooler_d = (state_d == ST_COOL);
    fault_d  = (state_d == ST_FAULT);
  end

  // State, counters and registered Moore outputs.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      on_cnt_q   <= '0;
      dead_cnt_q <= '0;
      inc_cnt_q  <= '0;
      heater_q   <= 1'b0;
      cooler_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      on_cnt_q   <= on_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      inc_cnt_q  <= inc_cnt_d;
      heater_q   <= heater_d;
      cooler_q   <= cooler_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.heater = heater_q;
  assign bus.cooler = cooler_q;
  assign bus.fault  = fault_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_greenhouse_climate_ctrl.sv
// Directed-vector bench for greenhouse_climate_ctrl with MIN_ON=4, DEAD=2,
// FAULT_FILT=3. Each vector applies t1/t2/clr_fault for one clock and states
// the FSM encoding expected after that edge; heater/cooler/fault are expected
// to be the Moore decode of that state.
module tb_greenhouse_climate_ctrl;

  logic clk_2;
  logic reset_n;

  greenhouse_climate_ctrl_if bus ();

  greenhouse_climate_ctrl #(
    .MIN_ON     (4),
    .DEAD       (2),
    .FAULT_FILT (3),
    .CNT_W      (8)
  ) dut (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic       t1;
    logic       t2;
    logic       clr;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare state and the three drive outputs against one expected state.
  task automatic check_state(input string tag, input logic [2:0] st);
    check({tag, ".state"},  8'(bus.state),  8'(st));
    check({tag, ".heater"}, 8'(bus.heater), 8'(st == 3'd1));
    check({tag, ".cooler"}, 8'(bus.cooler), 8'(st == 3'd2));
    check({tag, ".fault"},  8'(bus.fault),  8'(st == 3'd4));
  endtask

  task automatic step(input logic a, input logic b, input logic c);
    bus.t1        = a;
    bus.t2        = b;
    bus.clr_fault = c;
    @(posedge clk_2);
    #1;
  endtask

  task automatic add(input logic a, input logic b, input logic c,
                     input logic [2:0] st, input int n);
    vec_t v;
    v.t1 = a; v.t2 = b; v.clr = c; v.st = st;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.t1        = 1'b0;
    bus.t2        = 1'b0;
    bus.clr_fault = 1'b0;

    // Reset held with heat demand present: nothing may turn on.
    #2;
    check_state("rst_async", 3'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_state("rst_held", 3'd0);
    reset_n = 1'b1;

    // Short heat pulse: 4 cycles on, 2 dead, idle.
    add(0, 0, 0, 3'd1, 1);
    add(1, 0, 0, 3'd1, 3);
    add(1, 0, 0, 3'd3, 2);
    add(1, 0, 0, 3'd0, 1);
    // Heat held 10 cycles, then cool: dead, idle, cool, then cool min-on.
    add(0, 0, 0, 3'd1, 10);
    add(1, 1, 0, 3'd3, 2);
    add(1, 1, 0, 3'd0, 1);
    add(1, 1, 0, 3'd2, 2);
    add(1, 0, 0, 3'd2, 2);
    add(1, 0, 0, 3'd3, 2);
    add(1, 0, 0, 3'd0, 1);
    // Two inconsistent cycles do not latch the fault.
    add(0, 1, 0, 3'd0, 2);
    add(1, 0, 0, 3'd0, 1);
    // Three inconsistent cycles while heating latch it.
    add(0, 0, 0, 3'd1, 1);
    add(0, 1, 0, 3'd1, 2);
    add(0, 1, 0, 3'd4, 1);
    // Clear while still inconsistent is ignored; valid clear returns to idle;
    // next request served on the following cycle.
    add(0, 1, 1, 3'd4, 1);
    add(1, 0, 1, 3'd0, 1);
    add(0, 0, 0, 3'd1, 1);
    add(1, 0, 0, 3'd1, 3);
    add(1, 0, 0, 3'd3, 2);
    add(1, 0, 0, 3'd0, 1);
    // Clear in idle has no effect.
    add(1, 0, 1, 3'd0, 1);
    // Fault overrides cooler min-on.
    add(1, 1, 0, 3'd2, 1);
    add(0, 1, 0, 3'd2, 2);
    add(0, 1, 0, 3'd4, 1);
    // Long inconsistency in FAULT (counter saturation), then clear.
    add(0, 1, 0, 3'd4, 5);
    add(0, 1, 1, 3'd4, 1);
    add(1, 0, 1, 3'd0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].t1, vecs[i].t2, vecs[i].clr);
      check_state($sformatf("vec%0d", i), vecs[i].st);
      check($sformatf("vec%0d.excl", i), 8'(bus.heater & bus.cooler), 8'd0);
    end

    // Asynchronous reset in the middle of heating.
    step(1'b0, 1'b0, 1'b0);
    check_state("mid_heat0", 3'd1);
    step(1'b0, 1'b0, 1'b0);
    check_state("mid_heat1", 3'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_state("rst_mid_heat", 3'd0);
    step(1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check_state("post_rst", 3'd0);
    step(1'b0, 1'b0, 1'b0);
    check_state("post_rst_heat", 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
